pio_button_poller: RTL and testbench

- Avalon-MM master that polls the 2-bit button PIO slave (data register at address 0, registered readdata, no waitrequest from the slave itself).
- Periodically issues single-word reads, debounces each bit, and presents a clean logical button state plus one-cycle press/release event pulses to hardware consumers.
- Sits between the fabric port of the button PIO and local logic (LED/UART control FSMs) that must not depend on the Nios II for button handling.

---
 rtl/pio_poll_pkg.sv | 14 +
 rtl/pio_debounce_bit.sv | 75 +++++++
 rtl/pio_button_poller.sv | 107 ++++++++++
 tb/tb_pio_button_poller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// rtl/pio_poll_pkg.sv - shared FSM states and constants for the button PIO poller
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EVAL = 2'd3
  } poll_state_e;

  // The button PIO exposes its input data register at word 0.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - per-bit debouncer with registered press/release pulses
module pio_debounce_bit #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic eval,
  input  logic sample,
  output logic state,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CNT);

  logic          cand_q, cand_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_next;

  // Candidate tracking, saturating run counter and accept/pulse decision.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    cnt_next = cnt_q;
    if (eval) begin
      if (sample == state_q) begin
        cnt_d = '0;
      end else begin
        if (sample != cand_q) begin
          cand_d   = sample;
          cnt_next = CW'(1);
        end else if (cnt_q != CNT_LIMIT) begin
          cnt_next = cnt_q + CW'(1);
        end
        if (cnt_next == CNT_LIMIT) begin
          state_d = sample;
          cnt_d   = '0;
          press_d = sample;
          rel_d   = ~sample;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end
  end

  // Debounce state registers; pulses default low so they last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state         = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/pio_button_poller.sv
// rtl/pio_button_poller.sv - Avalon-MM master polling the button PIO and debouncing it
module pio_button_poller
  import pio_poll_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             sample_strobe
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TW-1:0]    TIMER_MAX = TW'(POLL_DIV - 1);
  localparam logic [1:0]       LAT_LAST  = 2'(READ_LATENCY - 1);
  localparam logic [WIDTH-1:0] POL_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;

  poll_state_e      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       lat_q, lat_d;
  logic             poll_req;
  logic             eval_now;
  logic [WIDTH-1:0] logical_sample;
  logic             unused_readdata;

  assign poll_req       = enable && (timer_q == TIMER_MAX);
  assign eval_now       = (state_q == WAIT) && (lat_q == LAT_LAST);
  assign logical_sample = avm_readdata[WIDTH-1:0] ^ POL_MASK;
  assign unused_readdata = ^avm_readdata[31:WIDTH];

  // Poll timer: free-running while enabled, parked at zero otherwise.
  always_comb begin
    timer_d = '0;
    if (enable) begin
      timer_d = (timer_q == TIMER_MAX) ? '0 : timer_q + TW'(1);
    end
  end

  // Read sequencing; requests arriving outside IDLE are simply ignored.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (poll_req) state_d = REQ;
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_d = WAIT;
          lat_d   = '0;
        end
      end
      WAIT: begin
        if (lat_q == LAT_LAST) state_d = EVAL;
        else                   lat_d   = lat_q + 2'd1;
      end
      EVAL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer, FSM and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
    end
  end

  // Address is constant; the strobe coincides with the registered debounce result.
  assign avm_read      = (state_q == REQ);
  assign avm_address   = PIO_DATA_ADDR;
  assign sample_strobe = (state_q == EVAL);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_db (
      .clk          (clk),
      .reset        (reset),
      .eval         (eval_now),
      .sample       (logical_sample[i]),
      .state        (btn_state[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_pio_button_poller.sv
// tb/tb_pio_button_poller.sv - self-checking bench for pio_button_poller
module tb_pio_button_poller;

  localparam int WIDTH = 2;
  localparam int DB    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  btn_state, btn_press, btn_release;
  logic        sample_strobe;

  logic [31:0] raw_src;
  logic [31:0] slv_q;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_state;
  int         run [WIDTH];

  pio_button_poller #(
    .WIDTH(WIDTH), .POLL_DIV(8), .DEBOUNCE_CNT(DB), .ACTIVE_LOW(1), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  // Slave with registered readdata: captured on the accepting edge.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) slv_q <= raw_src;
  end
  assign avm_readdata = slv_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = '0;
    for (int i = 0; i < WIDTH; i++) run[i] = 0;
  endtask

  // A bit is accepted once DB consecutive samples disagree with the accepted state.
  task automatic model_step(input logic [1:0] raw, output logic [1:0] ep, output logic [1:0] er);
    logic [1:0] s;
    s  = ~raw;
    ep = '0;
    er = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != m_state[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          m_state[i] = s[i];
          run[i]     = 0;
          if (s[i]) ep[i] = 1'b1;
          else      er[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic do_poll(input logic [1:0] raw, input int ws, input bit drop_en,
                         output logic [1:0] o_state, output logic [1:0] o_press,
                         output logic [1:0] o_rel);
    int n;
    logic [1:0] ep, er;
    raw_src = ($urandom() & 32'hFFFF_FFFC) | {30'd0, raw};
    avm_waitrequest = (ws > 0);
    n = 0;
    while (!avm_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(avm_read), 32'd1);
    if (drop_en) enable = 1'b0;
    for (int k = 0; k < ws; k++) begin
      chk("stall_read", 32'(avm_read), 32'd1);
      chk("stall_addr", 32'(avm_address), 32'd0);
      @(negedge clk);
    end
    chk("accept_read", 32'(avm_read), 32'd1);
    avm_waitrequest = 1'b0;
    n = 0;
    while (!sample_strobe && n < 10) begin
      chk("pulse_idle", 32'({btn_press, btn_release}), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("strobe_latency", 32'(n), 32'd2);
    model_step(raw, ep, er);
    chk("state", 32'(btn_state), 32'(m_state));
    chk("press", 32'(btn_press), 32'(ep));
    chk("release", 32'(btn_release), 32'(er));
    o_state = btn_state;
    o_press = btn_press;
    o_rel   = btn_release;
    @(negedge clk);
    chk("strobe_once", 32'(sample_strobe), 32'd0);
    chk("pulse_once", 32'({btn_press, btn_release}), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic [1:0] os, op, orl;
    logic [1:0] bounce [7];
    logic [1:0] r;
    int hold;

    reset = 1'b1;
    enable = 1'b1;
    avm_waitrequest = 1'b0;
    raw_src = 32'h3;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_state", 32'(btn_state), 32'd0);
    chk("rst_press", 32'(btn_press), 32'd0);
    chk("rst_release", 32'(btn_release), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!avm_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_read_cycle", 32'(n), 32'd8);

    // Press bit 0.
    for (int k = 0; k < 3; k++) do_poll(2'b10, 0, 1'b0, os, op, orl);
    chk("press0_state", 32'(os), 32'd1);
    chk("press0_press", 32'(op), 32'd1);
    chk("press0_release", 32'(orl), 32'd0);

    // Release it again.
    for (int k = 0; k < 3; k++) do_poll(2'b11, 0, 1'b0, os, op, orl);
    chk("rel0_release", 32'(orl), 32'd1);
    chk("rel0_state", 32'(os), 32'd0);

    // Bounce: only the 7th sample completes a run of three.
    bounce = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
    for (int k = 0; k < 7; k++) begin
      do_poll(bounce[k], 0, 1'b0, os, op, orl);
      if (k < 6) chk("bounce_early", 32'(op), 32'd0);
      else       chk("bounce_final", 32'(op), 32'd1);
    end

    // Five-cycle stall: the poll request lands in EVAL and is dropped.
    do_poll(2'b10, 5, 1'b0, os, op, orl);
    n = 1;
    while (!avm_read && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("stall_gap", 32'(n), 32'd9);

    // Simultaneous press on bit 1 and release on bit 0.
    for (int k = 0; k < 3; k++) do_poll(2'b01, 0, 1'b0, os, op, orl);
    chk("simul_press", 32'(op), 32'h2);
    chk("simul_release", 32'(orl), 32'h1);
    chk("simul_state", 32'(os), 32'h2);

    // Reset during a stalled request drops avm_read without a clock.
    avm_waitrequest = 1'b1;
    n = 0;
    while (!avm_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_seen", 32'(avm_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_read", 32'(avm_read), 32'd0);
    chk("mid_rst_state", 32'(btn_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    model_reset();

    // Disable during REQ: the read completes, then the bus stays quiet.
    do_poll(2'b11, 0, 1'b1, os, op, orl);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (avm_read) cnt++;
      @(negedge clk);
    end
    chk("disabled_reads", 32'(cnt), 32'd0);
    enable = 1'b1;

    // Random raw patterns held for random numbers of polls, random stalls.
    for (int k = 0; k < 60; k += hold) begin
      r    = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++)
        do_poll(r, $urandom_range(0, 2), 1'b0, os, op, orl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
